// File: rtl/rvseed_test_ctrl.sv
// Regression sequencer for the RVSEED core: per test, load image, run, score x26/x27, clear dmem and regfile.
// Load takes one cycle per accepted word (source is ready only in LOAD); clear takes 2^DMEM_AW cycles.
module rvseed_test_ctrl #(
    parameter int CPU_WIDTH    = 32,
    parameter int IMEM_AW      = 10,
    parameter int DMEM_AW      = 10,
    parameter int TEST_NUM     = 37,
    parameter int TIMEOUT_CYC  = 500,
    parameter int STOP_ON_FAIL = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [5:0]           ld_test_idx,
    input  logic                 ld_valid,
    output logic                 ld_ready,
    input  logic [CPU_WIDTH-1:0] ld_data,
    input  logic                 ld_last,
    output logic                 imem_we,
    output logic [IMEM_AW-1:0]   imem_addr,
    output logic [CPU_WIDTH-1:0] imem_wdata,
    output logic                 core_rst_n,
    input  logic                 core_done,
    input  logic                 core_pass,
    input  logic [CPU_WIDTH-1:0] core_testnum,
    output logic                 dmem_clr_we,
    output logic [DMEM_AW-1:0]   dmem_clr_addr,
    output logic                 rf_clr,
    output logic                 busy,
    output logic                 finished,
    output logic [5:0]           pass_cnt,
    output logic [5:0]           fail_cnt,
    output logic [5:0]           fail_idx,
    output logic [CPU_WIDTH-1:0] fail_testnum,
    output logic                 timeout
);
    localparam int RUN_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_RUN, S_SETTLE, S_CHECK, S_CLEAR, S_FINISH
    } state_t;

    state_t               state_q, state_d;
    logic [5:0]           idx_q, idx_d;
    logic [IMEM_AW-1:0]   iaddr_q, iaddr_d;
    logic [DMEM_AW-1:0]   daddr_q, daddr_d;
    logic [RUN_W-1:0]     run_q, run_d;
    logic [5:0]           pass_q, pass_d;
    logic [5:0]           fail_q, fail_d;
    logic [5:0]           fidx_q, fidx_d;
    logic [CPU_WIDTH-1:0] ftn_q, ftn_d;
    logic                 tmo_q, tmo_d;
    logic                 cur_fail_q, cur_fail_d;
    logic                 beat;

    assign ld_ready      = (state_q == S_LOAD);
    assign beat          = ld_valid && ld_ready;
    assign imem_we       = beat;
    assign imem_addr     = iaddr_q;
    assign imem_wdata    = ld_data;
    assign core_rst_n    = (state_q == S_RUN) || (state_q == S_SETTLE) || (state_q == S_CHECK);
    assign dmem_clr_we   = (state_q == S_CLEAR);
    assign dmem_clr_addr = daddr_q;
    // The clear address restarts at zero on every CLEAR entry, so it marks the first cycle.
    assign rf_clr        = (state_q == S_CLEAR) && (daddr_q == '0);
    assign busy          = (state_q != S_IDLE) && (state_q != S_FINISH);
    assign finished      = (state_q == S_FINISH);
    assign ld_test_idx   = idx_q;
    assign pass_cnt      = pass_q;
    assign fail_cnt      = fail_q;
    assign fail_idx      = fidx_q;
    assign fail_testnum  = ftn_q;
    assign timeout       = tmo_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            iaddr_q    <= '0;
            daddr_q    <= '0;
            run_q      <= '0;
            pass_q     <= '0;
            fail_q     <= '0;
            fidx_q     <= '0;
            ftn_q      <= '0;
            tmo_q      <= 1'b0;
            cur_fail_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            iaddr_q    <= iaddr_d;
            daddr_q    <= daddr_d;
            run_q      <= run_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            fidx_q     <= fidx_d;
            ftn_q      <= ftn_d;
            tmo_q      <= tmo_d;
            cur_fail_q <= cur_fail_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        iaddr_d    = iaddr_q;
        daddr_d    = daddr_q;
        run_d      = run_q;
        pass_d     = pass_q;
        fail_d     = fail_q;
        fidx_d     = fidx_q;
        ftn_d      = ftn_q;
        tmo_d      = tmo_q;
        cur_fail_d = cur_fail_q;
        case (state_q)
            S_IDLE, S_FINISH: begin
                if (start) begin
                    state_d    = S_LOAD;
                    idx_d      = '0;
                    iaddr_d    = '0;
                    daddr_d    = '0;
                    run_d      = '0;
                    pass_d     = '0;
                    fail_d     = '0;
                    fidx_d     = '0;
                    ftn_d      = '0;
                    tmo_d      = 1'b0;
                    cur_fail_d = 1'b0;
                end
            end
            S_LOAD: begin
                if (beat) begin
                    iaddr_d = iaddr_q + 1'b1;
                    if (ld_last || (iaddr_q == '1)) begin
                        state_d = S_RUN;
                        iaddr_d = '0;
                        run_d   = '0;
                    end
                end
            end
            S_RUN: begin
                if (core_done) begin
                    state_d = S_SETTLE;
                    run_d   = '0;
                end else if (run_q == RUN_W'(TIMEOUT_CYC - 1)) begin
                    state_d    = S_CLEAR;
                    run_d      = '0;
                    fail_d     = fail_q + 6'd1;
                    cur_fail_d = 1'b1;
                    if (fail_q == '0) begin
                        fidx_d = idx_q;
                        ftn_d  = '1;
                        tmo_d  = 1'b1;
                    end
                end else begin
                    run_d = run_q + 1'b1;
                end
            end
            S_SETTLE: state_d = S_CHECK;
            S_CHECK: begin
                state_d = S_CLEAR;
                if (core_pass) begin
                    pass_d = pass_q + 6'd1;
                end else begin
                    fail_d     = fail_q + 6'd1;
                    cur_fail_d = 1'b1;
                    if (fail_q == '0) begin
                        fidx_d = idx_q;
                        ftn_d  = core_testnum;
                        tmo_d  = 1'b0;
                    end
                end
            end
            S_CLEAR: begin
                daddr_d = daddr_q + 1'b1;
                if (daddr_q == '1) begin
                    if ((idx_q == 6'(TEST_NUM - 1)) || ((STOP_ON_FAIL != 0) && cur_fail_q)) begin
                        state_d = S_FINISH;
                    end else begin
                        state_d    = S_LOAD;
                        idx_d      = idx_q + 6'd1;
                        cur_fail_d = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_rvseed_test_ctrl.sv
// Bench for rvseed_test_ctrl: table-driven and random regressions against a behavioural outcome model.
module tb_rvseed_test_ctrl;
    localparam int K_PASS = 0, K_FAIL = 1, K_TMO = 2;
    localparam int BUDGET = 15000;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        start_i[2], ld_valid_i[2], ld_last_i[2], core_done_i[2], core_pass_i[2];
    logic [31:0] ld_data_i[2], core_testnum_i[2];
    logic [5:0]  ld_test_idx_o[2], pass_cnt_o[2], fail_cnt_o[2], fail_idx_o[2];
    logic        ld_ready_o[2], imem_we_o[2], core_rst_n_o[2], dmem_clr_we_o[2], rf_clr_o[2];
    logic        busy_o[2], finished_o[2], timeout_o[2];
    logic [4:0]  imem_addr_o[2];
    logic [31:0] imem_wdata_o[2], fail_testnum_o[2];
    logic [9:0]  dmem_clr_addr_o[2];

    // Instance 0: three tests, record-and-continue. Instance 1: six tests, stop on first failure.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        rvseed_test_ctrl #(
            .CPU_WIDTH(32), .IMEM_AW(5), .DMEM_AW(10), .TEST_NUM(g == 0 ? 3 : 6),
            .TIMEOUT_CYC(500), .STOP_ON_FAIL(g == 0 ? 0 : 1)
        ) u_dut (
            .clk(clk), .rst_n(rst_n), .start(start_i[g]),
            .ld_test_idx(ld_test_idx_o[g]), .ld_valid(ld_valid_i[g]), .ld_ready(ld_ready_o[g]),
            .ld_data(ld_data_i[g]), .ld_last(ld_last_i[g]),
            .imem_we(imem_we_o[g]), .imem_addr(imem_addr_o[g]), .imem_wdata(imem_wdata_o[g]),
            .core_rst_n(core_rst_n_o[g]), .core_done(core_done_i[g]), .core_pass(core_pass_i[g]),
            .core_testnum(core_testnum_i[g]),
            .dmem_clr_we(dmem_clr_we_o[g]), .dmem_clr_addr(dmem_clr_addr_o[g]), .rf_clr(rf_clr_o[g]),
            .busy(busy_o[g]), .finished(finished_o[g]), .pass_cnt(pass_cnt_o[g]),
            .fail_cnt(fail_cnt_o[g]), .fail_idx(fail_idx_o[g]),
            .fail_testnum(fail_testnum_o[g]), .timeout(timeout_o[g])
        );
    end

    typedef struct {
        int               sel;
        bit               bp;
        logic [5:0][1:0]  kind;
        logic [5:0][8:0]  k;
        logic [5:0][5:0]  len;
        logic [5:0][31:0] gp;
        int               e_pass, e_fail, e_fidx, e_loads;
        logic [31:0]      e_ftn;
        bit               e_tmo;
    } scen_t;

    scen_t       tbl[6];
    int          cfg_kind[6], cfg_k[6], cfg_len[6];
    logic [31:0] cfg_gp[6];
    bit          cfg_bp;
    int          checks = 0, errors = 0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endfunction

    task automatic set_t(input int s, input int t, input int kind, input int k, input int len,
                         input logic [31:0] gp);
        tbl[s].kind[t] = 2'(kind);
        tbl[s].k[t]    = 9'(k);
        tbl[s].len[t]  = 6'(len);
        tbl[s].gp[t]   = gp;
    endtask

    task automatic set_e(input int s, input int sel, input bit bp, input int p, input int f,
                         input int fi, input logic [31:0] ftn, input bit tmo, input int loads);
        tbl[s].sel = sel; tbl[s].bp = bp; tbl[s].e_pass = p; tbl[s].e_fail = f;
        tbl[s].e_fidx = fi; tbl[s].e_ftn = ftn; tbl[s].e_tmo = tmo; tbl[s].e_loads = loads;
    endtask

    // Outcome model: walk the tests in order, counting and recording the first failure.
    task automatic ref_model(input int n, input bit stop, output int ep, output int ef, output int efi,
                             output logic [31:0] eftn, output bit etmo, output int eloads);
        ep = 0; ef = 0; efi = 0; eftn = '0; etmo = 1'b0; eloads = 0;
        for (int t = 0; t < n; t++) begin
            eloads++;
            if (cfg_kind[t] == K_PASS) begin
                ep++;
            end else begin
                if (ef == 0) begin
                    efi  = t;
                    etmo = (cfg_kind[t] == K_TMO);
                    eftn = etmo ? 32'hFFFF_FFFF : cfg_gp[t];
                end
                ef++;
                if (stop) break;
            end
        end
    endtask

    task automatic check_reset(input int sel, input string tag);
        chk({tag, "_core_rst_n"}, 64'(core_rst_n_o[sel]), 0);
        chk({tag, "_ld_ready"}, 64'(ld_ready_o[sel]), 0);
        chk({tag, "_imem_we"}, 64'(imem_we_o[sel]), 0);
        chk({tag, "_dmem_clr_we"}, 64'(dmem_clr_we_o[sel]), 0);
        chk({tag, "_rf_clr"}, 64'(rf_clr_o[sel]), 0);
        chk({tag, "_busy"}, 64'(busy_o[sel]), 0);
        chk({tag, "_finished"}, 64'(finished_o[sel]), 0);
        chk({tag, "_timeout"}, 64'(timeout_o[sel]), 0);
        chk({tag, "_counts"}, {pass_cnt_o[sel], fail_cnt_o[sel], fail_idx_o[sel], ld_test_idx_o[sel]}, 0);
        chk({tag, "_addrs"}, {imem_addr_o[sel], dmem_clr_addr_o[sel]}, 0);
        chk({tag, "_fail_testnum"}, 64'(fail_testnum_o[sel]), 0);
    endtask

    task automatic run_reg(input int sel, input int e_pass, input int e_fail, input int e_fidx,
                           input logic [31:0] e_ftn, input bit e_tmo, input int e_loads,
                           input int abort_at);
        int cyc = 0, ptr = 0, cur = 0, r = -1, hi = 0, clr_i = 0, clr_tot = 0, exp_hi;
        int err_load = 0, err_idx = 0, err_we = 0, err_addr = 0, err_data = 0;
        int err_clr = 0, err_rf = 0, err_run = 0, err_busy = 0, err_seq = 0;
        bit prev_rdy = 1'b0, end_pend = 1'b0, rdy, hs;
        int seq[$];
        @(negedge clk);
        start_i[sel] = 1'b1;
        forever begin
            @(negedge clk);
            cyc++;
            start_i[sel] = 1'b0;
            if (cyc > BUDGET) begin
                checks++; errors++;
                $display("FAIL cycle_budget: got %0d cycles without finished, required <= %0d", cyc, BUDGET);
                break;
            end
            if (abort_at >= 0 && cur == abort_at && r == 3) begin
                rst_n = 1'b0;
                #1;
                check_reset(sel, "midrun_rst");
                #1;
                rst_n = 1'b1;
                return;
            end
            rdy = ld_ready_o[sel];
            if (end_pend && rdy) err_load++;
            if (!end_pend && prev_rdy && !rdy) err_load++;
            end_pend = 1'b0;
            if (rdy && !prev_rdy) begin
                ptr = 0;
                cur = int'(ld_test_idx_o[sel]);
                seq.push_back(cur);
            end else if (rdy && int'(ld_test_idx_o[sel]) != cur) begin
                err_idx++;
            end
            prev_rdy = rdy;
            if (busy_o[sel] == finished_o[sel]) err_busy++;
            if (dmem_clr_we_o[sel]) begin
                if (int'(dmem_clr_addr_o[sel]) != clr_i) err_clr++;
                if (rf_clr_o[sel] != (clr_i == 0)) err_rf++;
                clr_i++;
                clr_tot++;
            end else begin
                if (clr_i != 0 && clr_i != 1024) err_clr++;
                clr_i = 0;
                if (rf_clr_o[sel]) err_rf++;
            end
            // Core released for RUN+SETTLE+CHECK after completion at k, or exactly the timeout window.
            if (core_rst_n_o[sel]) begin
                r++;
                hi++;
            end else begin
                if (hi > 0) begin
                    exp_hi = (cfg_kind[cur] == K_TMO) ? 500 : cfg_k[cur] + 3;
                    if (hi != exp_hi) err_run++;
                end
                hi = 0;
                r  = -1;
            end
            if (finished_o[sel]) break;
            if (busy_o[sel] && $urandom_range(0, 199) == 0) start_i[sel] = 1'b1;
            if (rdy) begin
                ld_valid_i[sel] = cfg_bp ? (cyc % 2 == 0) : 1'b1;
                ld_last_i[sel]  = (ptr == cfg_len[cur] - 1);
                ld_data_i[sel]  = $urandom;
            end else begin
                ld_valid_i[sel] = ($urandom_range(0, 3) == 0);
                ld_last_i[sel]  = 1'($urandom_range(0, 1));
                ld_data_i[sel]  = $urandom;
            end
            if (r < 0) begin
                core_done_i[sel] = 1'($urandom_range(0, 1));
                core_pass_i[sel] = 1'($urandom_range(0, 1));
            end else begin
                core_done_i[sel] = (cfg_kind[cur] != K_TMO) && (r >= cfg_k[cur]);
                core_pass_i[sel] = (r >= cfg_k[cur] + 1) ? (cfg_kind[cur] == K_PASS)
                                                         : 1'($urandom_range(0, 1));
            end
            core_testnum_i[sel] = cfg_gp[cur];
            #1;
            hs = ld_valid_i[sel] && rdy;
            if (imem_we_o[sel] != hs) err_we++;
            if (hs) begin
                if (int'(imem_addr_o[sel]) != ptr) err_addr++;
                if (imem_wdata_o[sel] != ld_data_i[sel]) err_data++;
                if (ld_last_i[sel] || ptr == 31) end_pend = 1'b1;
                ptr++;
            end
        end
        repeat (3) begin
            @(negedge clk);
            core_done_i[sel] = 1'($urandom_range(0, 1));
            core_pass_i[sel] = 1'($urandom_range(0, 1));
            ld_valid_i[sel]  = 1'($urandom_range(0, 1));
        end
        #1;
        for (int i = 0; i < seq.size(); i++) if (seq[i] != i) err_seq++;
        chk("pass_cnt", 64'(pass_cnt_o[sel]), 64'(e_pass));
        chk("fail_cnt", 64'(fail_cnt_o[sel]), 64'(e_fail));
        chk("fail_idx", 64'(fail_idx_o[sel]), 64'(e_fidx));
        chk("fail_testnum", 64'(fail_testnum_o[sel]), 64'(e_ftn));
        chk("timeout", 64'(timeout_o[sel]), 64'(e_tmo));
        chk("finished_held", {finished_o[sel], busy_o[sel], core_rst_n_o[sel], imem_we_o[sel]}, 64'h8);
        chk("loads_requested", 64'(seq.size()), 64'(e_loads));
        chk("load_order", 64'(err_seq), 0);
        chk("clr_cycles", 64'(clr_tot), 64'(e_loads * 1024));
        chk("load_end", 64'(err_load), 0);
        chk("idx_stable", 64'(err_idx), 0);
        chk("imem_we_handshake", 64'(err_we), 0);
        chk("imem_addr_contig", 64'(err_addr), 0);
        chk("imem_wdata", 64'(err_data), 0);
        chk("clr_addr_seq", 64'(err_clr), 0);
        chk("rf_clr_pulse", 64'(err_rf), 0);
        chk("run_window", 64'(err_run), 0);
        chk("busy_finished", 64'(err_busy), 0);
    endtask

    task automatic load_cfg(input int s);
        for (int t = 0; t < 6; t++) begin
            cfg_kind[t] = int'(tbl[s].kind[t]);
            cfg_k[t]    = int'(tbl[s].k[t]);
            cfg_len[t]  = int'(tbl[s].len[t]);
            cfg_gp[t]   = tbl[s].gp[t];
        end
        cfg_bp = tbl[s].bp;
    endtask

    initial begin
        int sel, ep, ef, efi, el, v;
        logic [31:0] eftn;
        bit etmo;
        rst_n = 1'b0;
        for (int g = 0; g < 2; g++) begin
            start_i[g] = 1'b0; ld_valid_i[g] = 1'b0; ld_last_i[g] = 1'b0; ld_data_i[g] = '0;
            core_done_i[g] = 1'b0; core_pass_i[g] = 1'b0; core_testnum_i[g] = '0;
        end
        for (int s = 0; s < 6; s++) for (int t = 0; t < 6; t++) set_t(s, t, K_PASS, 5, 4, 32'h0);
        set_e(0, 0, 0, 3, 0, 0, 32'h0, 0, 3);
        for (int t = 0; t < 3; t++) set_t(0, t, K_PASS, 20, 4, 32'h0);
        set_e(1, 0, 1, 2, 1, 0, 32'hFFFF_FFFF, 1, 3);
        set_t(1, 0, K_TMO, 0, 5, 32'h9);
        set_t(1, 1, K_PASS, 30, 6, 32'h0);
        set_t(1, 2, K_PASS, 499, 3, 32'h0);
        set_e(2, 1, 0, 2, 1, 2, 32'h7, 0, 3);
        set_t(2, 0, K_PASS, 20, 4, 32'h0);
        set_t(2, 1, K_PASS, 7, 6, 32'h0);
        set_t(2, 2, K_FAIL, 15, 4, 32'h7);
        set_e(3, 0, 0, 1, 2, 1, 32'h55, 0, 3);
        set_t(3, 1, K_FAIL, 12, 7, 32'h55);
        set_t(3, 2, K_TMO, 0, 2, 32'h66);
        set_e(4, 1, 0, 6, 0, 0, 32'h0, 0, 6);
        set_t(4, 0, K_PASS, 10, 40, 32'h0);
        set_t(4, 1, K_PASS, 4, 32, 32'h0);
        set_t(4, 2, K_PASS, 0, 1, 32'h0);
        set_t(4, 4, K_PASS, 50, 8, 32'h0);
        set_e(5, 1, 0, 0, 1, 0, 32'hFFFF_FFFF, 1, 1);
        set_t(5, 0, K_TMO, 0, 4, 32'h3);

        repeat (3) @(negedge clk);
        check_reset(0, "rst0");
        check_reset(1, "rst1");
        rst_n = 1'b1;
        @(negedge clk);

        for (int s = 0; s < 6; s++) begin
            load_cfg(s);
            run_reg(tbl[s].sel, tbl[s].e_pass, tbl[s].e_fail, tbl[s].e_fidx, tbl[s].e_ftn,
                    tbl[s].e_tmo, tbl[s].e_loads, -1);
        end

        repeat (3) begin
            sel = $urandom_range(0, 1);
            for (int t = 0; t < 6; t++) begin
                v = $urandom_range(0, 99);
                cfg_kind[t] = (v < 72) ? K_PASS : (v < 84) ? K_FAIL : (v < 92) ? K_TMO : K_PASS;
                cfg_k[t]    = (v >= 92) ? 499 : $urandom_range(0, 60);
                cfg_len[t]  = $urandom_range(1, 40);
                cfg_gp[t]   = $urandom;
            end
            cfg_bp = 1'($urandom_range(0, 1));
            ref_model(sel == 0 ? 3 : 6, sel == 1, ep, ef, efi, eftn, etmo, el);
            run_reg(sel, ep, ef, efi, eftn, etmo, el, -1);
        end

        for (int t = 0; t < 6; t++) begin
            cfg_kind[t] = K_PASS; cfg_k[t] = 10; cfg_len[t] = 4; cfg_gp[t] = '0;
        end
        cfg_bp = 1'b0;
        run_reg(1, 0, 0, 0, '0, 0, 0, 5);
        ld_valid_i[1] = 1'b0;
        @(negedge clk);
        check_reset(1, "post_rst");
        start_i[1] = 1'b1;
        @(negedge clk);
        start_i[1] = 1'b0;
        chk("restart_ld_ready", 64'(ld_ready_o[1]), 1);
        chk("restart_idx", 64'(ld_test_idx_o[1]), 0);
        chk("restart_pass_cnt", 64'(pass_cnt_o[1]), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
